// File: rtl/buzzer_sfx_scheduler.sv
// buzzer_sfx_scheduler: fixed-priority sound-effect sequencer for the buzzer tone generator.
// Three event requesters (jump < score < game-over) share one buzzer. The selected effect's note
// table is played as scale codes held for whole duration ticks, with optional silent gaps
// between notes. A higher-priority request preempts the effect that is playing.
module buzzer_sfx_scheduler #(
    parameter int TICK_DIV  = 2_500_000,
    parameter int GAP_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_req,
    input  logic       i_mute,
    output logic [5:0] o_music_scale,
    output logic       o_busy,
    output logic [1:0] o_effect,
    output logic       o_done
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]    GAP_LAST = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    typedef struct packed {
        logic [5:0] scale;
        logic [3:0] ticks;
        logic       last;
    } note_t;

    // Effect note ROM, indexed by effect id and note position within the effect
    function automatic note_t note_rom(input logic [1:0] eff, input logic [1:0] idx);
        note_t n;
        n = '{scale: 6'd0, ticks: 4'd1, last: 1'b1};
        case ({eff, idx})
            4'b01_00: n = '{scale: 6'd15, ticks: 4'd4,  last: 1'b0};
            4'b01_01: n = '{scale: 6'd17, ticks: 4'd4,  last: 1'b1};
            4'b10_00: n = '{scale: 6'd13, ticks: 4'd3,  last: 1'b0};
            4'b10_01: n = '{scale: 6'd17, ticks: 4'd3,  last: 1'b0};
            4'b10_10: n = '{scale: 6'd20, ticks: 4'd6,  last: 1'b1};
            4'b11_00: n = '{scale: 6'd20, ticks: 4'd6,  last: 1'b0};
            4'b11_01: n = '{scale: 6'd17, ticks: 4'd6,  last: 1'b0};
            4'b11_10: n = '{scale: 6'd13, ticks: 4'd6,  last: 1'b0};
            4'b11_11: n = '{scale: 6'd8,  ticks: 4'd12, last: 1'b1};
            default:  ;
        endcase
        return n;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    eff_q, eff_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    tick_q, tick_d;
    logic [5:0]    scale_q, scale_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    note_t      cur_note, nxt_note;
    logic [1:0] req_id;
    logic       cyc_end;

    // Next-state: arbitration/preemption, note and gap timing, registered output values
    always_comb begin
        state_d  = state_q;
        eff_d    = eff_q;
        idx_d    = idx_q;
        cyc_d    = cyc_q;
        tick_d   = tick_q;
        done_d   = 1'b0;
        cur_note = note_rom(eff_q, idx_q);
        cyc_end  = (cyc_q == CYC_LAST);

        if (i_req[2])      req_id = 2'd3;
        else if (i_req[1]) req_id = 2'd2;
        else if (i_req[0]) req_id = 2'd1;
        else               req_id = 2'd0;

        // eff_q is 0 in IDLE, so one compare covers both new starts and strict preemption
        if (req_id > eff_q) begin
            state_d = NOTE;
            eff_d   = req_id;
            idx_d   = 2'd0;
            cyc_d   = '0;
            tick_d  = 4'd0;
        end else begin
            case (state_q)
                NOTE: begin
                    if (!cyc_end) begin
                        cyc_d = cyc_q + 1'b1;
                    end else begin
                        cyc_d = '0;
                        if (tick_q != cur_note.ticks - 4'd1) begin
                            tick_d = tick_q + 4'd1;
                        end else begin
                            tick_d = 4'd0;
                            if (cur_note.last) begin
                                state_d = IDLE;
                                eff_d   = 2'd0;
                                idx_d   = 2'd0;
                                done_d  = 1'b1;
                            end else if (GAP_TICKS > 0) begin
                                state_d = GAP;
                            end else begin
                                idx_d = idx_q + 2'd1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (!cyc_end) begin
                        cyc_d = cyc_q + 1'b1;
                    end else begin
                        cyc_d = '0;
                        if (tick_q != GAP_LAST) begin
                            tick_d = tick_q + 4'd1;
                        end else begin
                            tick_d  = 4'd0;
                            state_d = NOTE;
                            idx_d   = idx_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        nxt_note = note_rom(eff_d, idx_d);
        scale_d  = (state_d == NOTE && !i_mute) ? nxt_note.scale : 6'd0;
        busy_d   = (state_d != IDLE);
    end

    // State, counters and registered outputs; reset discards any effect in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            eff_q   <= 2'd0;
            idx_q   <= 2'd0;
            cyc_q   <= '0;
            tick_q  <= 4'd0;
            scale_q <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            eff_q   <= eff_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            tick_q  <= tick_d;
            scale_q <= scale_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_music_scale = scale_q;
    assign o_busy        = busy_q;
    assign o_effect      = eff_q;
    assign o_done        = done_q;

endmodule
